// File: rtl/user_auth_pkg.sv
// Shared types and constants for the user session authentication block.
// KEY_TABLE is indexed by user id; entry 0 is never consulted because the guest id always fails.
package user_auth_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CHECK,
        ACTIVE,
        LOCKED
    } auth_state_t;

    localparam logic [2:0] GUEST_ID = 3'h0;

    localparam logic [7:0][7:0] KEY_TABLE = {
        8'h0F,  // id 7
        8'h69,  // id 6
        8'hC3,  // id 5
        8'hA5,  // id 4
        8'h96,  // id 3
        8'h5A,  // id 2
        8'h3C,  // id 1
        8'h00   // id 0 (guest)
    };

endpackage

// File: rtl/auth_timer.sv
// Loadable saturating down-counter shared by lockout and session-timeout timing.
// It holds at zero instead of wrapping, and a load takes priority over a decrement.
module auth_timer #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/user_session_auth.sv
// Login and session controller: checks credentials, tracks the active session with an idle timeout,
// and locks out new requests after repeated failures.
module user_session_auth
    import user_auth_pkg::*;
#(
    parameter int MAX_FAIL    = 3,
    parameter int LOCK_CYCLES = 16,
    parameter int TIMEOUT     = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [2:0] req_id,
    input  logic [7:0] req_key,
    input  logic       logout,
    input  logic       activity,
    output logic [2:0] usr_id,
    output logic       session_active,
    output logic       locked,
    output logic       auth_ok,
    output logic       auth_fail
);

    localparam int LW  = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
    localparam int TOW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int TW  = (LW > TOW) ? LW : TOW;
    localparam int FW  = $clog2(MAX_FAIL + 1);

    auth_state_t   state, next_state;
    logic [2:0]    id_q;
    logic [7:0]    key_q;
    logic [FW-1:0] fail_cnt;
    logic          key_match;
    logic          timer_load, timer_dec, timer_zero;
    logic [TW-1:0] timer_load_val;
    logic          fail_inc, fail_clr;

    assign key_match = (id_q != GUEST_ID) && (key_q == KEY_TABLE[id_q]);

    auth_timer #(.W(TW)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (timer_load),
        .load_val (timer_load_val),
        .dec      (timer_dec),
        .zero     (timer_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    // The timer counts down the remaining idle allowance in ACTIVE and the remaining lockout in LOCKED.
    always_comb begin
        next_state     = state;
        timer_load     = 1'b0;
        timer_load_val = '0;
        timer_dec      = 1'b0;
        fail_inc       = 1'b0;
        fail_clr       = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid && req_ready) next_state = CHECK;
            end
            CHECK: begin
                if (key_match) begin
                    next_state     = ACTIVE;
                    timer_load     = 1'b1;
                    timer_load_val = TW'(TIMEOUT - 1);
                    fail_clr       = 1'b1;
                end else begin
                    fail_inc = 1'b1;
                    if (fail_cnt >= FW'(MAX_FAIL - 1)) begin
                        next_state     = LOCKED;
                        timer_load     = 1'b1;
                        timer_load_val = TW'(LOCK_CYCLES - 1);
                    end else begin
                        next_state = IDLE;
                    end
                end
            end
            ACTIVE: begin
                if (logout) begin
                    next_state = IDLE;
                end else if (activity) begin
                    timer_load     = 1'b1;
                    timer_load_val = TW'(TIMEOUT - 1);
                end else if (timer_zero) begin
                    next_state = IDLE;
                end else begin
                    timer_dec = 1'b1;
                end
            end
            LOCKED: begin
                if (timer_zero) begin
                    next_state = IDLE;
                    fail_clr   = 1'b1;
                end else begin
                    timer_dec = 1'b1;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_q     <= GUEST_ID;
            key_q    <= '0;
            fail_cnt <= '0;
        end else begin
            if (state == IDLE && req_valid && req_ready) begin
                id_q  <= req_id;
                key_q <= req_key;
            end
            if (fail_clr)                                 fail_cnt <= '0;
            else if (fail_inc && fail_cnt != FW'(MAX_FAIL)) fail_cnt <= fail_cnt + 1'b1;
        end
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_ready      <= 1'b0;
            usr_id         <= GUEST_ID;
            session_active <= 1'b0;
            locked         <= 1'b0;
            auth_ok        <= 1'b0;
            auth_fail      <= 1'b0;
        end else begin
            req_ready      <= (next_state == IDLE);
            session_active <= (next_state == ACTIVE);
            locked         <= (next_state == LOCKED);
            auth_ok        <= (state == CHECK) && key_match;
            auth_fail      <= (state == CHECK) && !key_match;
            if (state == CHECK && next_state == ACTIVE) usr_id <= id_q;
            else if (next_state != ACTIVE)              usr_id <= GUEST_ID;
        end
    end

endmodule
